// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port data RAM between the instruction-fetch port (IF) and
// the load/store port (MEM). One access is granted per cycle. MEM byte/half/
// word requests become RAM byte-lane selects plus lane-replicated write data.
// Load data is lane-extracted and sign/zero-extended. Every grant produces a
// registered response one cycle later.
//
// Arbitration: a lone requester always wins. When both request, MEM wins
// unless IF has already been refused STARVE_LIMIT cycles in a row.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   : misaligned half/word MEM accesses are granted but not issued
//               to the RAM; the response carries mem_err = 1 and zero data.
//   undefined : low address bits are truncated to the access size and the
//               access proceeds normally; mem_err is always 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req / if_addr           IF read request, word address ([1:0] ignored)
//   if_gnt                     IF accepted this cycle (combinational)
//   if_rvalid / if_rdata       IF read response (registered)
//   mem_req / mem_we           MEM request, 1 = store, 0 = load
//   mem_size / mem_unsigned    00 byte, 01 half, 1x word; zero-extend loads
//   mem_addr / mem_wdata       MEM byte address, right-aligned store data
//   mem_gnt                    MEM accepted this cycle (combinational)
//   mem_rvalid / mem_rdata     MEM response (registered), data 0 for stores
//   mem_err                    misaligned access, qualified by mem_rvalid
//   ram_ce / ram_we            RAM chip / write enable
//   ram_addr / ram_sel         word-aligned RAM address, byte-lane select
//   ram_wdata / ram_rdata      lane-replicated write data, combinational read
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [31:0]       mem_rdata,
   output logic              mem_err,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_sel,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      SIZE_BYTE     = 2'b00,
      SIZE_HALF     = 2'b01,
      SIZE_WORD     = 2'b10,
      SIZE_WORD_ALT = 2'b11
   } size_e;

   size_e            mem_size_e;
   logic             is_byte;
   logic             is_half;
   logic [1:0]       lane_ofs;       // size-aligned byte offset inside the word
   logic             mem_misalign;
   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic [3:0]       store_sel;
   logic [31:0]      store_wdata;
   logic [7:0]       load_byte;
   logic [15:0]      load_half;
   logic [31:0]      load_data;
   logic             unused_if_lo;

   // The IF port always fetches whole words.
   assign unused_if_lo = ^if_addr[1:0];

   assign mem_size_e = size_e'(mem_size);
   assign is_byte    = (mem_size_e == SIZE_BYTE);
   assign is_half    = (mem_size_e == SIZE_HALF);

`ifdef MISALIGN_TRAP_EN
   assign mem_misalign = is_half ? mem_addr[0] : (!is_byte && (mem_addr[1:0] != 2'b00));
`else
   assign mem_misalign = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Arbitration and starvation counter
   // ---------------------------------------------------------------------------
   always_comb begin
      if_gnt  = if_req & (~mem_req | (starve_cnt_q == CNT_SAT));
      mem_gnt = mem_req & ~if_gnt;
   end

   // NOTE: every variable driven in a combinational block gets a default
   // assignment first, so no path through the block can infer a latch.
   always_comb begin
      starve_cnt_d = '0;
      if (if_req && !if_gnt) begin
         starve_cnt_d = (starve_cnt_q == CNT_SAT) ? CNT_SAT : starve_cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // MEM lane decode: truncation to the size alignment happens here, so a
   // non-trapping misaligned access simply uses the aligned lane(s).
   // ---------------------------------------------------------------------------
   always_comb begin
      lane_ofs = 2'b00;
      if (is_byte) begin
         lane_ofs = mem_addr[1:0];
      end else if (is_half) begin
         lane_ofs = {mem_addr[1], 1'b0};
      end
   end

   always_comb begin
      store_sel   = 4'b1111;
      store_wdata = mem_wdata;
      if (is_byte) begin
         store_sel   = 4'b0001 << lane_ofs;
         store_wdata = {4{mem_wdata[7:0]}};
      end else if (is_half) begin
         store_sel   = lane_ofs[1] ? 4'b1100 : 4'b0011;
         store_wdata = {2{mem_wdata[15:0]}};
      end
   end

   always_comb begin
      case (lane_ofs)
         2'd0:    load_byte = ram_rdata[7:0];
         2'd1:    load_byte = ram_rdata[15:8];
         2'd2:    load_byte = ram_rdata[23:16];
         default: load_byte = ram_rdata[31:24];
      endcase
      load_half = lane_ofs[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      if (is_byte) begin
         load_data = {{24{~mem_unsigned & load_byte[7]}}, load_byte};
      end else if (is_half) begin
         load_data = {{16{~mem_unsigned & load_half[15]}}, load_half};
      end else begin
         load_data = ram_rdata;
      end
   end

   // ---------------------------------------------------------------------------
   // RAM drive. A trapped misaligned MEM grant leaves ce/we/sel low.
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_sel   = 4'b0000;
      ram_wdata = '0;
      if (if_gnt) begin
         ram_ce   = 1'b1;
         ram_addr = {if_addr[ADDR_W-1:2], 2'b00};
         ram_sel  = 4'b1111;
      end else if (mem_gnt) begin
         ram_addr = {mem_addr[ADDR_W-1:2], 2'b00};
         if (!mem_misalign) begin
            ram_ce    = 1'b1;
            ram_we    = mem_we;
            ram_sel   = mem_we ? store_sel : 4'b1111;
            ram_wdata = mem_we ? store_wdata : 32'h0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State: starvation counter and the one-cycle registered responses.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
         mem_err    <= 1'b0;
      end else begin
         if_rvalid  <= if_gnt;
         mem_rvalid <= mem_gnt;
         mem_err    <= mem_gnt & mem_misalign;
         if (if_gnt) begin
            if_rdata <= ram_rdata;
         end
         if (mem_gnt) begin
            mem_rdata <= (mem_we || mem_misalign) ? 32'h0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Bench for data_mem_arbiter. Provides a 64-word data RAM (combinational read,
// byte-lane write on posedge) and checks the DUT with:
//   - reset values,
//   - a table of MEM load/store vectors with fixed expected results,
//   - starvation grant pattern and reset-clears-counter sequences,
//   - reset during an IF grant,
//   - randomized IF/MEM traffic against a byte-level reference memory.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
// Define MISALIGN_TRAP_EN for both DUT and bench to cover the trapping build.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int ADDR_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int RAND_CYCLES  = 400;

   logic              clk;
   logic              rst_n;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic              mem_unsigned;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_err;
   logic              ram_ce;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_sel;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int checks   = 0;
   int failures = 0;

   logic        preload;
   logic [31:0] ram_arr [0:63];   // the RAM seen by the DUT
   logic [31:0] ref_mem [0:63];   // expected RAM contents

   data_mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .mem_err      (mem_err),
      .ram_ce       (ram_ce),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_sel      (ram_sel),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // RAM model
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      case (i)
         4:       return 32'h8421F0E7;
         8:       return 32'h11223344;
         12:      return 32'h0;
         default: return {b, ~b, b ^ 8'h5A, 8'hC3};
      endcase
   endfunction

   assign ram_rdata = ram_arr[ram_addr[7:2]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) ram_arr[i] <= init_word(i);
      end else if (ram_ce && ram_we) begin
         for (int l = 0; l < 4; l++) begin
            if (ram_sel[l]) ram_arr[ram_addr[7:2]][8*l +: 8] <= ram_wdata[8*l +: 8];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model helpers (byte arithmetic on the architectural rules)
   // ---------------------------------------------------------------------------
   function automatic int nbytes_of(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic misaligned_of(input logic [1:0] size, input logic [31:0] addr);
      return ((addr % 4) % nbytes_of(size)) != 0;
   endfunction

   function automatic int offset_of(input logic [1:0] size, input logic [31:0] addr);
      int a;
      a = int'(addr % 4);
      return a - (a % nbytes_of(size));
   endfunction

   function automatic logic trap_of(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
      return misaligned_of(size, addr);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [31:0] addr);
      longint v;
      longint full;
      int     nb;
      nb   = nbytes_of(size);
      full = longint'(1) << (8 * nb);
      v    = (longint'(word) >> (8 * offset_of(size, addr))) & (full - 1);
      if (!uns && v >= full / 2) v = v - full;
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] addr);
      int m;
      m = ((1 << nbytes_of(size)) - 1) << offset_of(size, addr);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) r[8*l +: 8] = wdata[8*(l % nbytes_of(size)) +: 8];
      return r;
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      int idx;
      int off;
      idx = int'((addr / 4) % 64);
      off = offset_of(size, addr);
      for (int b = 0; b < nbytes_of(size); b++) ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed MEM vectors
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_sel;
      logic [31:0] exp_wdata;
      logic        exp_ce;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic [3:0] exp_sel,
                               input logic [31:0] exp_wdata, input logic exp_ce, input logic exp_err);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_sel = exp_sel; v.exp_wdata = exp_wdata;
      v.exp_ce = exp_ce; v.exp_err = exp_err;
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 two cycles later.
   task automatic mem_op(input int n, input vec_t v);
      string t;
      t = $sformatf("vec%0d", n);
      if_req = 1'b0; mem_req = 1'b1; mem_we = v.we; mem_size = v.size;
      mem_unsigned = v.uns; mem_addr = v.addr; mem_wdata = v.wdata;
      @(negedge clk);
      check({t, "_gnt"},    mem_gnt, 1'b1);
      check({t, "_ifgnt"},  if_gnt, 1'b0);
      check({t, "_rv_idle"}, mem_rvalid, 1'b0);
      check({t, "_ce"},     ram_ce, v.exp_ce);
      check({t, "_we"},     ram_we, v.we & v.exp_ce);
      check({t, "_sel"},    ram_sel, v.exp_sel);
      check({t, "_wdata"},  ram_wdata, v.exp_wdata);
      if (v.exp_ce) check({t, "_addr"}, ram_addr, (v.addr / 4) * 4);
      if (v.we && v.exp_ce) model_store(v.size, v.addr, v.wdata);
      @(posedge clk); #1;
      mem_req = 1'b0;
      @(negedge clk);
      check({t, "_rvalid"}, mem_rvalid, 1'b1);
      check({t, "_rdata"},  mem_rdata, v.exp_rdata);
      check({t, "_err"},    mem_err, v.exp_err);
      @(posedge clk); #1;
   endtask

   // Both ports request continuously from a zero starvation count; returns
   // at the negedge of the last cycle with both requests still asserted.
   task automatic run_starve(input string t, input int n);
      logic prev_if;
      logic prev_mem;
      logic exp_if;
      prev_if = 1'b0; prev_mem = 1'b0;
      if_req = 1'b1; if_addr = 32'h20;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0; mem_addr = 32'h10;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         exp_if = (k % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
         check($sformatf("%s_ifgnt%0d", t, k), if_gnt, exp_if);
         check($sformatf("%s_memgnt%0d", t, k), mem_gnt, !exp_if);
         check($sformatf("%s_ifrv%0d", t, k), if_rvalid, prev_if);
         check($sformatf("%s_memrv%0d", t, k), mem_rvalid, prev_mem);
         if (prev_if) check($sformatf("%s_ifrd%0d", t, k), if_rdata, ref_mem[8]);
         if (prev_mem) check($sformatf("%s_memrd%0d", t, k), mem_rdata, ref_mem[4]);
         prev_if = exp_if; prev_mem = !exp_if;
         if (k != n - 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   logic        if_pend, mem_pend, g_if, g_mem, trap;
   logic        e_if_rv, e_mem_rv, e_mem_err;
   logic [31:0] e_if_rd, e_mem_rd;
   int          exp_cnt;

   initial begin
      preload = 1'b1; rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_size = 2'd0; mem_unsigned = 1'b0; mem_addr = '0; mem_wdata = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

      // Reset values
      @(negedge clk);
      check("rst_if_rvalid",  if_rvalid, 1'b0);
      check("rst_if_rdata",   if_rdata, 32'h0);
      check("rst_mem_rvalid", mem_rvalid, 1'b0);
      check("rst_mem_rdata",  mem_rdata, 32'h0);
      check("rst_mem_err",    mem_err, 1'b0);
      check("rst_ram_ce",     ram_ce, 1'b0);
      preload = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed MEM table
      vq.push_back(mk(0, 0, 0, 32'h10, 0,      32'hFFFFFFE7, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 0, 1, 32'h13, 0,      32'h00000084, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 1, 0, 32'h12, 0,      32'hFFFF8421, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h10, 0,      32'h8421F0E7, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 1, 1, 32'h10, 0,      32'h0000F0E7, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 32'h12, 0,      32'h00000021, 4'hF, 0, 1, 0));
      vq.push_back(mk(1, 0, 0, 32'h21, 32'hAB, 32'h0, 4'b0010, 32'hABABABAB, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h20, 0,      32'h1122AB44, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 32'h21, 0,      32'hFFFFFFAB, 4'hF, 0, 1, 0));
      vq.push_back(mk(1, 1, 0, 32'h32, 32'h5566, 32'h0, 4'b1100, 32'h55665566, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h30, 0,      32'h55660000, 4'hF, 0, 1, 0));
`ifdef MISALIGN_TRAP_EN
      vq.push_back(mk(1, 1, 0, 32'h31, 32'h7788, 32'h0, 4'b0000, 32'h0, 0, 1));
      vq.push_back(mk(0, 2, 0, 32'h30, 0,      32'h55660000, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h13, 0,      32'h0, 4'b0000, 0, 0, 1));
`else
      vq.push_back(mk(1, 1, 0, 32'h31, 32'h7788, 32'h0, 4'b0011, 32'h77887788, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h30, 0,      32'h55667788, 4'hF, 0, 1, 0));
      vq.push_back(mk(0, 2, 0, 32'h13, 0,      32'h8421F0E7, 4'hF, 0, 1, 0));
`endif
      vq.push_back(mk(1, 3, 0, 32'h34, 32'hDEADBEEF, 32'h0, 4'hF, 32'hDEADBEEF, 1, 0));
      vq.push_back(mk(0, 3, 1, 32'h34, 0,      32'hDEADBEEF, 4'hF, 0, 1, 0));
      foreach (vq[i]) mem_op(i, vq[i]);

      // Starvation pattern M,M,M,M,I repeating
      run_starve("starve", 10);
      @(posedge clk); #1;
      if_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      check("starve_tail_ifrv",  if_rvalid, 1'b1);
      check("starve_tail_memrv", mem_rvalid, 1'b0);
      check("starve_tail_ifrd",  if_rdata, ref_mem[8]);
      @(posedge clk); #1;

      // Reset with a part-built starvation count must restart the pattern
      run_starve("pre_rst", 3);
      #1 rst_n = 1'b0;
      if_req = 1'b0; mem_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_starve("post_rst", 10);
      @(posedge clk); #1;
      if_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      check("post_rst_tail_ifrv", if_rvalid, 1'b1);
      @(posedge clk); #1;

      // Reset during an IF grant cycle
      if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b0;
      @(negedge clk);
      check("rstA_gnt0", if_gnt, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstA_gnt1",    if_gnt, 1'b1);
      check("rstA_rv_pre",  if_rvalid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("rstA_async_ifrv",  if_rvalid, 1'b0);
      check("rstA_async_ifrd",  if_rdata, 32'h0);
      check("rstA_async_memrd", mem_rdata, 32'h0);
      if_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rstA_after_ifrv",  if_rvalid, 1'b0);
      check("rstA_after_memrv", mem_rvalid, 1'b0);
      check("rstA_after_err",   mem_err, 1'b0);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h24;
      @(negedge clk);
      check("rstA_first_gnt", if_gnt, 1'b1);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      check("rstA_first_rv", if_rvalid, 1'b1);
      check("rstA_first_rd", if_rdata, ref_mem[9]);
      @(posedge clk); #1;

      // Randomized traffic against the reference model
      if_pend = 1'b0; mem_pend = 1'b0; exp_cnt = 0;
      e_if_rv = 1'b0; e_mem_rv = 1'b0; e_mem_err = 1'b0; e_if_rd = '0; e_mem_rd = '0;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         if (!if_pend) begin
            if_req  = ($urandom % 10) < 6;
            if_addr = $urandom_range(0, 255);
         end
         if (!mem_pend) begin
            mem_req      = ($urandom % 10) < 6;
            mem_we       = $urandom_range(0, 1);
            mem_size     = 2'($urandom_range(0, 3));
            mem_unsigned = $urandom_range(0, 1);
            mem_addr     = $urandom_range(0, 255);
            mem_wdata    = $urandom;
         end
         @(negedge clk);
         check("rnd_ifrv", if_rvalid, e_if_rv);
         if (e_if_rv) check("rnd_ifrd", if_rdata, e_if_rd);
         check("rnd_memrv", mem_rvalid, e_mem_rv);
         if (e_mem_rv) begin
            check("rnd_memrd", mem_rdata, e_mem_rd);
            check("rnd_memerr", mem_err, e_mem_err);
         end
         g_if  = if_req && (!mem_req || exp_cnt >= STARVE_LIMIT);
         g_mem = mem_req && !g_if;
         check("rnd_ifgnt", if_gnt, g_if);
         check("rnd_memgnt", mem_gnt, g_mem);
         exp_cnt = (if_req && !g_if) ? ((exp_cnt < STARVE_LIMIT) ? exp_cnt + 1 : exp_cnt) : 0;
         e_if_rv = g_if; e_mem_rv = g_mem;
         if (g_if) begin
            e_if_rd = ref_mem[(if_addr / 4) % 64];
            check("rnd_if_ce", ram_ce, 1'b1);
            check("rnd_if_we", ram_we, 1'b0);
            check("rnd_if_sel", ram_sel, 4'hF);
            check("rnd_if_addr", ram_addr, (if_addr / 4) * 4);
         end else if (g_mem) begin
            trap = trap_of(mem_size, mem_addr);
            e_mem_err = trap;
            e_mem_rd  = 32'h0;
            check("rnd_mem_ce", ram_ce, !trap);
            check("rnd_mem_we", ram_we, mem_we && !trap);
            if (trap) begin
               check("rnd_trap_sel", ram_sel, 4'h0);
            end else begin
               check("rnd_mem_addr", ram_addr, (mem_addr / 4) * 4);
               if (mem_we) begin
                  check("rnd_st_sel", ram_sel, model_sel(mem_size, mem_addr));
                  check("rnd_st_wdata", ram_wdata, model_wdata(mem_size, mem_wdata));
                  model_store(mem_size, mem_addr, mem_wdata);
               end else begin
                  check("rnd_ld_sel", ram_sel, 4'hF);
                  e_mem_rd = model_load(ref_mem[(mem_addr / 4) % 64], mem_size, mem_unsigned, mem_addr);
               end
            end
         end else begin
            check("rnd_idle_ce", ram_ce, 1'b0);
            check("rnd_idle_sel", ram_sel, 4'h0);
         end
         if_pend  = if_req && !g_if;
         mem_pend = mem_req && !g_mem;
         @(posedge clk); #1;
      end
      if_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      check("rnd_tail_ifrv", if_rvalid, e_if_rv);
      check("rnd_tail_memrv", mem_rvalid, e_mem_rv);
      if (e_if_rv) check("rnd_tail_ifrd", if_rdata, e_if_rd);
      if (e_mem_rv) check("rnd_tail_memrd", mem_rdata, e_mem_rd);
      @(posedge clk); #1;

      // Final RAM contents against the reference memory
      for (int i = 0; i < 64; i++) check($sformatf("ram_word%0d", i), ram_arr[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
